fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage sitting directly downstream of the program counter and upstream of decode. Accepts fetch addresses from the PC over a valid/ready handshake and issues reads to a fixed one-cycle-latency instruction memory. Buffers returned instructions, tagged with their PC, in a small FIFO. Presents them to decode in order and discards all buffered and in-flight work on a taken-branch flush.

## Interface
Parameters:
- ADDRESS_SIZE, 6, PC width is 2**ADDRESS_SIZE bits (64 by default); memory word index is the low ADDRESS_SIZE bits of the PC
- INSTR_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock; all state updates on rising edge
  - rst  in  1  reset
- PC handshake:
  - pc_in  in  2**ADDRESS_SIZE  fetch address (word-indexed, PC increments by 1)
  - pc_valid  in  1  pc_in valid
  - pc_ready  out  1  queue can accept an address this cycle
- Flush:
  - flush  in  1  taken branch (pc_src); kill everything
- Instruction memory:
  - imem_req  out  1  read strobe
  - imem_addr  out  ADDRESS_SIZE  word index = pc_in[ADDRESS_SIZE-1:0]
  - imem_rdata  in  INSTR_W  read data, valid the cycle after imem_req
- Decode handshake:
  - instr_valid  out  1  head entry valid
  - instr_ready  in  1  decode consumes head
  - instr_data  out  INSTR_W  head instruction
  - instr_pc  out  2**ADDRESS_SIZE  head PC

## Operation
- Accept: `pc_ready = !rst && !flush && (count + inflight < DEPTH)`.
  - A transfer occurs when pc_valid && pc_ready.
  - In that same cycle, imem_req=1 and imem_addr is driven combinationally; pc_in is latched as inflight_pc and inflight is set.
- Response: in the cycle after a request with inflight=1 and no kill, imem_rdata and inflight_pc are enqueued.
  - Back-to-back requests are allowed; inflight stays 1.
- Credit rule: a response always has a slot, so overflow is impossible by construction. An enqueue when count==DEPTH is an assertion failure.
- Dequeue: occurs when instr_valid && instr_ready. The head advances and count decrements.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- Flush (highest priority):
  - count ← 0 and pointers ← 0.
  - A request accepted in the flush cycle is impossible (pc_ready=0).
  - A response returning in the cycle after flush is discarded via the kill flag. kill is set on flush when inflight=1 and cleared when that response retires.
  - A dequeue in the flush cycle has no effect beyond the flush.
- Reset: count=0, pointers=0, inflight=0, kill=0.
  - Outputs during and after reset: pc_ready=0 while rst=1, imem_req=0, instr_valid=0, instr_data=32'h00000013 (NOP), instr_pc=0.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Empty-queue outputs: instr_data and instr_pc hold the last dequeued values. With no dequeue since reset/flush, they hold NOP and 0.

## Timing
- Request latency: pc accepted at cycle T → imem_req in T → rdata in T+1.
- Without bypass: enqueued at the edge ending T+1 → instr_valid at T+2. Fetch-to-decode latency is 2.
- With bypass (see Configuration): instr_valid at T+1 when the queue is empty.
- Throughput: one instruction per cycle sustained while instr_ready=1.
- Flush recovery: flush at cycle F → pc_ready=1 at F+1 → first new instruction valid at F+3 (F+2 with bypass).
- No combinational path from instr_ready to pc_ready, except via registered count.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When the queue is empty and a non-killed response arrives, imem_rdata/inflight_pc are driven onto instr_data/instr_pc with instr_valid=1 in the same cycle.
  - If instr_ready=1, the entry is not written. Otherwise it is enqueued normally.
- Undefined: all responses pass through the queue; outputs are taken from the head only.

## Structure
- Package fetch_pkg:
  - INSTR_W
  - NOP_INSTR = 32'h00000013
  - typedef fetch_entry_t {pc, instr}
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with clear input (flush), push/pop, count output.
- Top-level fetch_queue holds the credit logic, inflight/kill flags, and the bypass mux.

## Test plan
- Reset, then stream PC 0,1,2,3 with instr_ready=1 and imem returning 0x100+addr:
  - decode sees (0,0x100)…(3,0x103) in order, one per cycle, first at T+2 (T+1 with bypass).
- instr_ready=0, pc_valid held high:
  - pc_ready drops after 4 total outstanding (count+inflight=DEPTH); no overflow assertion fires.
  - Releasing instr_ready drains all 4 in order.
- Flush in the cycle after accepting PC 5 (response in flight):
  - PC 5 is never delivered; count=0; pc_ready=1 next cycle.
  - New PC 20 arrives at decode 2 cycles later.
- Flush with 3 entries queued and instr_ready=1 in the same cycle: no entry is consumed; instr_valid=0 the next cycle.
- Assert rst mid-stream with 2 entries queued:
  - Next cycle instr_valid=0, instr_data=0x00000013, instr_pc=0, imem_req=0.
- Full queue with simultaneous dequeue and enqueue: count stays at DEPTH-1 … DEPTH as expected; pointer wraps past index 3 to 0 without data loss.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : fetch_pkg                                              |
// | Description : Shared constants and entry type for the fetch queue.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;

  // addi x0, x0, 0 -- shown to decode whenever nothing has been delivered
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_fifo                                             |
// | Description : Synchronous FIFO of fetch entries with a clear input   |
// |               (flush), push/pop and an occupancy count.              |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_pkg::fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  T                       push_data_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T                mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            w_do_push;
  logic            w_do_pop;

  // Clear wins over both push and pop; popping an empty FIFO is ignored.
  assign w_do_push = push_i && !clr_i;
  assign w_do_pop  = pop_i && !clr_i && (count_q != '0);

  // Pointer and occupancy next-state; pointers wrap naturally modulo DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (w_do_push) wptr_d = wptr_q + PW'(1);
      if (w_do_pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates their use.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wptr_q] <= push_data_i;
  end

  // Upstream credit accounting must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst && !clr_i) assert (!(push_i && (count_q == CW'(DEPTH))));
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_queue                                            |
// | Description : Fetch stage between PC and decode. Issues one-cycle    |
// |               instruction-memory reads, buffers PC-tagged results in |
// |               a FIFO and drops all work on a taken-branch flush.     |
// |               Optional macro FETCH_QUEUE_BYPASS_EN forwards a fresh  |
// |               response straight to decode when the queue is empty.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fetch_queue #(
  parameter int ADDRESS_SIZE = 6,
  parameter int INSTR_W      = 32,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2**ADDRESS_SIZE-1:0] pc_in,
  input  logic                       pc_valid,
  output logic                       pc_ready,
  input  logic                       flush,
  output logic                       imem_req,
  output logic [ADDRESS_SIZE-1:0]    imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [INSTR_W-1:0]         instr_data,
  output logic [2**ADDRESS_SIZE-1:0] instr_pc
);

  import fetch_pkg::*;

  localparam int PC_W = 2**ADDRESS_SIZE;
  localparam int CW   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam entry_t c_EMPTY_ENTRY = '{pc: '0, instr: INSTR_W'(NOP_INSTR)};

  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  entry_t          last_q, last_d;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_outstanding;
  entry_t          w_head;
  entry_t          w_resp_entry;
  entry_t          w_out;
  logic            w_empty;
  logic            w_accept;
  logic            w_resp;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_deq;

  // Credit check: queued entries plus the one possibly in flight must leave a slot.
  always_comb begin
    w_outstanding = {1'b0, w_count} + (CW+1)'(inflight_q);
    pc_ready      = !rst && !flush && (w_outstanding < (CW+1)'(DEPTH));
  end

  assign w_accept  = pc_valid && pc_ready;
  assign imem_req  = w_accept;
  assign imem_addr = pc_in[ADDRESS_SIZE-1:0];

  // A response is live the cycle after its request unless killed or flushed now.
  assign w_resp       = inflight_q && !kill_q && !flush && !rst;
  assign w_resp_entry = '{pc: inflight_pc_q, instr: imem_rdata};
  assign w_empty      = (w_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && w_resp;
`else
  assign w_bypass = 1'b0;
`endif

  // Decode-facing mux: bypassed response, FIFO head, or the last delivered entry.
  always_comb begin
    w_out = last_q;
    if (rst)          w_out = c_EMPTY_ENTRY;
    else if (w_bypass) w_out = w_resp_entry;
    else if (!w_empty) w_out = w_head;
  end

  assign instr_valid = !rst && (!w_empty || w_bypass);
  assign instr_data  = w_out.instr;
  assign instr_pc    = w_out.pc;

  // A dequeue coinciding with a flush is swallowed by the flush.
  assign w_deq  = instr_valid && instr_ready && !flush;
  assign w_pop  = w_deq && !w_empty;
  assign w_push = w_resp && !(w_bypass && instr_ready);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (flush),
    .push_i      (w_push),
    .push_data_i (w_resp_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  // Next-state for the in-flight tracker, kill flag and held output entry.
  always_comb begin
    inflight_d    = w_accept;
    inflight_pc_d = w_accept ? pc_in : inflight_pc_q;
    // The response landing in the flush cycle is dropped by the FIFO clear;
    // kill only covers a request still outstanding across the flush edge.
    if (flush)           kill_d = imem_req;
    else if (inflight_q) kill_d = 1'b0;
    else                 kill_d = kill_q;
    if (flush)      last_d = c_EMPTY_ENTRY;
    else if (w_deq) last_d = w_out;
    else            last_d = last_q;
  end

  // Control and held-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
      inflight_pc_q <= '0;
      last_q        <= c_EMPTY_ENTRY;
    end else begin
      inflight_q    <= inflight_d;
      kill_q        <= kill_d;
      inflight_pc_q <= inflight_pc_d;
      last_q        <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                         |
// | Description : Scoreboard bench for fetch_queue: accepted PCs push an |
// |               expected entry, a monitor pops on each dequeue.        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [63:0] instr_pc;

  int errors    = 0;
  int checks    = 0;
  int delivered = 0;
  int acc;

  logic [63:0] exp_pc_q  [$];
  logic [31:0] exp_dat_q [$];

  fetch_queue #(.ADDRESS_SIZE(6), .INSTR_W(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address a holds 0x100 + a, one cycle latency.
  always @(posedge clk) imem_rdata <= imem_req ? (32'h100 + {26'd0, imem_addr}) : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: dequeues are compared in order; accepts push, flush/reset clear.
  always @(negedge clk) begin : monitor
    logic [63:0] p;
    logic [31:0] d;
    if (rst) begin
      exp_pc_q.delete();
      exp_dat_q.delete();
    end else begin
      if (instr_valid && instr_ready && !flush) begin
        delivered++;
        if (exp_pc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc %0h data %0h, expected nothing", instr_pc, instr_data);
        end else begin
          p = exp_pc_q.pop_front();
          d = exp_dat_q.pop_front();
          chk("sb_pc", instr_pc, p);
          chk("sb_data", 64'(instr_data), 64'(d));
        end
      end
      if (flush) begin
        exp_pc_q.delete();
        exp_dat_q.delete();
      end else if (pc_valid && pc_ready) begin
        exp_pc_q.push_back(pc_in);
        exp_dat_q.push_back(32'h100 + {26'd0, pc_in[5:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pc_valid = 1'b1; pc_in = 64'd7; flush = 1'b0; instr_ready = 1'b0;
    // Reset outputs
    sample();
    chk("rst_pc_ready", 64'(pc_ready), 64'd0);
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_data", 64'(instr_data), 64'(NOP));
    chk("rst_pc", instr_pc, 64'd0);
    step(); step();
    rst = 1'b0; pc_valid = 1'b0; instr_ready = 1'b1;

    // Stream PCs 0..3 with decode always ready
    for (int c = 0; c < 7; c++) begin
      pc_valid = (c < 4);
      pc_in    = 64'(c);
      sample();
      chk("t2_valid", 64'(instr_valid), 64'(c >= LAT && c < LAT + 4));
      if (c < 4) begin
        chk("t2_imem_req", 64'(imem_req), 64'd1);
        chk("t2_imem_addr", 64'(imem_addr), 64'(c));
      end
      step();
    end
    pc_valid = 1'b0;
    sample();
    chk("t2_hold_data", 64'(instr_data), 64'h103);
    chk("t2_hold_pc", instr_pc, 64'd3);
    step();

    // Back-pressure: four outstanding then pc_ready drops
    instr_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      pc_valid = 1'b1;
      pc_in    = 64'(8 + acc);
      sample();
      chk("t3_ready", 64'(pc_ready), 64'(c < 4));
      if (pc_ready) acc++;
      step();
    end
    pc_valid = 1'b0; instr_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("t3_drain_valid", 64'(instr_valid), 64'(c < 4));
      if (c == 4) chk("t3_last_pc", instr_pc, 64'd11);
      step();
    end

    // Flush one cycle after accepting PC 5
    pc_valid = 1'b1; pc_in = 64'd5;
    sample();
    chk("t4_accept5", 64'(pc_ready), 64'd1);
    step();
    pc_valid = 1'b0; flush = 1'b1;
    sample();
    chk("t4_flush_ready", 64'(pc_ready), 64'd0);
    step();
    flush = 1'b0; pc_valid = 1'b1; pc_in = 64'd20;
    sample();
    chk("t4_recover_ready", 64'(pc_ready), 64'd1);
    chk("t4_recover_valid", 64'(instr_valid), 64'd0);
    step();
    pc_valid = 1'b0;
    sample();
    chk("t4_f2_valid", 64'(instr_valid), 64'(LAT == 1));
    step();
    sample();
    chk("t4_f3_valid", 64'(instr_valid), 64'(LAT == 2));
    chk("t4_f3_pc", instr_pc, 64'd20);
    step();

    // Flush with three queued entries while decode is ready
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      pc_valid = 1'b1;
      pc_in    = 64'(30 + c);
      step();
    end
    pc_valid = 1'b0;
    step();
    flush = 1'b1; instr_ready = 1'b1;
    sample();
    chk("t5_head_pc", instr_pc, 64'd30);
    step();
    flush = 1'b0;
    sample();
    chk("t5_after_valid", 64'(instr_valid), 64'd0);
    chk("t5_after_ready", 64'(pc_ready), 64'd1);
    step();

    // Reset mid-stream with two entries queued
    instr_ready = 1'b0; pc_valid = 1'b1; pc_in = 64'd40;
    step();
    pc_in = 64'd41;
    step();
    pc_valid = 1'b0;
    step();
    sample();
    chk("t6_queued_valid", 64'(instr_valid), 64'd1);
    step();
    rst = 1'b1; pc_valid = 1'b1; pc_in = 64'd42;
    sample();
    chk("t6_rst_ready", 64'(pc_ready), 64'd0);
    step();
    rst = 1'b0; pc_valid = 1'b0;
    sample();
    chk("t6_valid", 64'(instr_valid), 64'd0);
    chk("t6_data", 64'(instr_data), 64'(NOP));
    chk("t6_pc", instr_pc, 64'd0);
    chk("t6_imem_req", 64'(imem_req), 64'd0);
    step();

    // Fill to DEPTH, then stream with simultaneous enqueue/dequeue across the wrap
    instr_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      pc_valid = 1'b1;
      pc_in    = 64'(50 + acc);
      sample();
      chk("t7_fill_ready", 64'(pc_ready), 64'(c < 4));
      if (pc_ready) acc++;
      step();
    end
    instr_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      pc_in = 64'(50 + acc);
      sample();
      chk("t7_stream_ready", 64'(pc_ready), 64'(c != 0));
      if (pc_ready) acc++;
      step();
    end
    pc_valid = 1'b0;
    for (int c = 0; c < 6; c++) step();
    sample();
    chk("t7_last_pc", instr_pc, 64'd62);
    chk("sb_leftover", 64'(exp_pc_q.size()), 64'd0);
    chk("delivered_total", 64'(delivered), 64'd22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
